// File: rtl/bpm_disp_ctrl.sv
// BPM display controller: clamps a binary BPM value to 999 and converts it to three BCD digits by double-dabble.
// Optional macro BPM_LZ_BLANK_EN enables leading-zero blanking of the hundreds/tens digits.
module bpm_disp_ctrl #(
  parameter int CONV_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CONV_BITS-1:0] bpm_in,
  input  logic                 bpm_valid,
  output logic                 bpm_ready,
  output logic [3:0]           dig2,
  output logic [3:0]           dig1,
  output logic [3:0]           dig0,
  output logic [2:0]           blank,
  output logic                 sat,
  output logic                 upd
);

  localparam int SW = CONV_BITS + 12;
  localparam int CW = $clog2(CONV_BITS + 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [SW-1:0]         r_sh;
  logic [CW-1:0]         r_cnt;
  logic                  r_clamp;
  logic [3:0]            r_dig2, r_dig1, r_dig0;
  logic                  r_sat;
  logic                  r_upd;

  logic [SW-1:0]         w_adj;
  logic [31:0]           w_in_ext;
  logic                  w_over;
  logic [CONV_BITS-1:0]  w_clamped;
  logic [3:0]            w_h, w_t, w_o;

  assign w_in_ext  = 32'(bpm_in);
  assign w_over    = (w_in_ext > 32'd999);
  assign w_clamped = w_over ? CONV_BITS'(999) : bpm_in;

  // BCD field sits above the binary field in one shift register
  assign w_h = r_sh[CONV_BITS+8 +: 4];
  assign w_t = r_sh[CONV_BITS+4 +: 4];
  assign w_o = r_sh[CONV_BITS   +: 4];

  always_comb begin
    w_adj = r_sh;
    for (int unsigned k = 0; k < 3; k++) begin
      if (r_sh[CONV_BITS + 4*k +: 4] >= 4'd5)
        w_adj[CONV_BITS + 4*k +: 4] = r_sh[CONV_BITS + 4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_clamp <= 1'b0;
      r_dig2  <= '0;
      r_dig1  <= '0;
      r_dig0  <= '0;
      r_sat   <= 1'b0;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bpm_valid && r_ready) begin
            r_sh    <= {12'b0, w_clamped};
            r_clamp <= w_over;
            r_cnt   <= CW'(CONV_BITS - 1);
            r_ready <= 1'b0;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_sh <= w_adj << 1;
          if (r_cnt == '0)
            r_state <= LOAD;
          else
            r_cnt <= r_cnt - 1'b1;
        end
        LOAD: begin
          r_dig2  <= w_h;
          r_dig1  <= w_t;
          r_dig0  <= w_o;
          r_sat   <= r_clamp;
          r_upd   <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BPM_LZ_BLANK_EN
  logic [2:0] r_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank <= 3'b110;
    end else if (r_state == LOAD) begin
      r_blank <= {(w_h == 4'd0), (w_h == 4'd0) && (w_t == 4'd0), 1'b0};
    end
  end

  assign blank = r_blank;
`else
  assign blank = 3'b000;
`endif

  assign bpm_ready = r_ready;
  assign dig2      = r_dig2;
  assign dig1      = r_dig1;
  assign dig0      = r_dig0;
  assign sat       = r_sat;
  assign upd       = r_upd;

endmodule

// File: doc/bpm_disp_ctrl.md
BPM_DISP_CTRL -- requirements
Module: bpm_disp_ctrl

Interface
REQ-001 SHALL have parameter CONV_BITS, default 10, width of the binary BPM input.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port bpm_in  input  CONV_BITS  binary BPM value to display.
REQ-005 SHALL have port bpm_valid  input  1  bpm_in valid this cycle.
REQ-006 SHALL have port bpm_ready  output  1  controller can accept a value.
REQ-007 SHALL have ports dig2/dig1/dig0  output  4 each  BCD hundreds/tens/ones nibbles for the three 7-segment decoders.
REQ-008 SHALL have port blank  output  3  per-digit blank request, bit2=hundreds; 1 = segments off.
REQ-009 SHALL have port sat  output  1  displayed value was clamped.
REQ-010 SHALL have port upd  output  1  one-cycle pulse when digit outputs change.

Function
REQ-011 SHALL implement FSM states IDLE, CONV and LOAD; bpm_ready SHALL be 1 only in IDLE.
REQ-012 Handshake: a transfer SHALL occur on an edge where bpm_valid=1 and bpm_ready=1; bpm_valid in CONV/LOAD SHALL be ignored, with no buffering.
REQ-013 On transfer, the controller SHALL capture min(bpm_in, 999) into a shift register and record a clamp flag (bpm_in>999), then go to CONV.
REQ-014 CONV SHALL run exactly CONV_BITS cycles of double-dabble: add 3 to each BCD nibble >=5, then shift the binary MSB into the BCD LSB, one bit per cycle.
REQ-015 After the last CONV cycle, the FSM SHALL go to LOAD; on the LOAD edge, dig2/dig1/dig0, blank and sat SHALL update and upd SHALL be 1 for exactly that following cycle; the FSM SHALL then return to IDLE.
REQ-016 Latency: transfer at edge E0 means outputs and upd change at edge E(CONV_BITS+1), i.e. E11 by default, and bpm_ready returns high at that same edge.
REQ-017 Maximum throughput SHALL be one value per CONV_BITS+2 cycles; back-to-back valid SHALL be accepted on the first IDLE cycle.
REQ-018 Outputs SHALL hold their last loaded values between updates; intermediate CONV values SHALL never appear on dig*.
REQ-019 Boundary values SHALL display as follows: 0 as 0/0/0; 999 as 9/9/9 with sat=0; 1000 and 2^CONV_BITS-1 (1023) as 9/9/9 with sat=1.
REQ-020 Every BCD nibble output SHALL be in range 0..9.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, dig2=dig1=dig0=0, sat=0, upd=0 and bpm_ready=1 once released; blank SHALL take its reset value per REQ-023/REQ-024.
REQ-022 Reset asserted during CONV or LOAD SHALL abort the conversion; no upd SHALL follow, and the first transfer after release SHALL convert normally.

Configuration
REQ-023 With macro BPM_LZ_BLANK_EN defined, blank[2] SHALL be 1 when dig2=0, and blank[1] SHALL be 1 when dig2=0 and dig1=0; blank[0] SHALL always be 0, so value 0 shows a single "0"; the reset value of blank SHALL be 3'b110.
REQ-024 Without BPM_LZ_BLANK_EN, blank SHALL be constant 3'b000, including during and after reset.

Verification
REQ-025 Reset, then a single transfer of 120: dig=1/2/0, sat=0, upd high exactly 11 cycles after the transfer edge, bpm_ready low for 11 cycles.
REQ-026 Transfers of 0, 999, 1000 and 1023: dig=0/0/0 sat=0; 9/9/9 sat=0; 9/9/9 sat=1; 9/9/9 sat=1.
REQ-027 bpm_valid held high continuously with values 60, 61, 62: exactly three upd pulses spaced 12 cycles apart; values pulsed in during CONV are dropped.
REQ-028 Assert rst_n low 5 cycles after the transfer of 200 and release it: no upd, dig=0/0/0, bpm_ready=1; a following transfer of 75 gives 0/7/5.
REQ-029 With BPM_LZ_BLANK_EN: transfer 7 gives blank=110; 45 gives 100; 180 gives 000; after reset blank=110. Without the macro: blank=000 in all these cases.
REQ-030 Random sweep of 0..1023 against a reference model: dig and sat correct for every value, and no nibble >9.
